// File: rtl/jk_pkg.sv
// Shared types for the JK sequence driver: FSM states and the
// don't-care resolution modes used by the excitation logic.
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic MODE_SR     = 1'b0;
  localparam logic MODE_TOGGLE = 1'b1;

endpackage

// File: rtl/jk_sequence_driver_if.sv
// Handshake/data bundle between the sequence driver and whoever
// starts runs and supplies the flop-under-test Q.
interface jk_sequence_driver_if #(
  parameter int LEN = 8
);
  localparam int IDX_W = $clog2(LEN + 1);

  logic             start;
  logic             mode;
  logic [LEN-1:0]   pattern;
  logic             q_in;
  logic             j_out;
  logic             k_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [IDX_W-1:0] err_count;
  logic [IDX_W-1:0] first_err_idx;

  modport master (
    output start, mode, pattern, q_in,
    input  j_out, k_out, busy, done, pass, err_count, first_err_idx
  );

  modport slave (
    input  start, mode, pattern, q_in,
    output j_out, k_out, busy, done, pass, err_count, first_err_idx
  );

endinterface

// File: rtl/jk_excite.sv
// JK excitation table: J/K needed to move Q from p to t, with the
// don't-care input resolved by mode (set/reset style or toggle style).
module jk_excite
  import jk_pkg::*;
(
  input  logic i_p,
  input  logic i_t,
  input  logic i_mode,
  output logic o_j,
  output logic o_k
);

  always_comb begin
    o_j = 1'b0;
    o_k = 1'b0;
    case ({i_p, i_t})
      2'b00: begin
        o_j = 1'b0;
        o_k = (i_mode == MODE_SR);
      end
      2'b01: begin
        o_j = 1'b1;
        o_k = (i_mode == MODE_TOGGLE);
      end
      2'b10: begin
        o_j = (i_mode == MODE_TOGGLE);
        o_k = 1'b1;
      end
      default: begin
        o_j = (i_mode == MODE_SR);
        o_k = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/jk_sequence_driver.sv
// Drives a JK flop through a target Q sequence and counts mismatches
// between the returned Q and the target, two cycles behind the drive.
module jk_sequence_driver
  import jk_pkg::*;
#(
  parameter int LEN = 8
) (
  input  logic clk,
  input  logic reset,
  jk_sequence_driver_if.slave bus
);

  localparam int IDX_W = $clog2(LEN + 1);

  state_t           r_state, w_state_nxt;
  logic [LEN-1:0]   r_pat, w_pat_nxt;
  logic             r_mode, w_mode_nxt;
  logic             r_prev, w_prev_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_drain, w_drain_nxt;
  logic             r_j, w_j_nxt;
  logic             r_k, w_k_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic [IDX_W-1:0] r_err, w_err_nxt;
  logic [IDX_W-1:0] r_first, w_first_nxt;
  // Expected-Q pipeline: stage 0 is written on the drive edge, stage 1 is compared.
  logic [1:0]       r_v, w_v_nxt;
  logic [1:0]       r_e, w_e_nxt;
  logic [IDX_W-1:0] r_i0, w_i0_nxt;
  logic [IDX_W-1:0] r_i1, w_i1_nxt;

  logic             w_push, w_push_exp;
  logic [IDX_W-1:0] w_push_idx;
  logic             w_mis;
  logic             w_j_exc, w_k_exc;

  jk_excite u_excite (
    .i_p    (r_prev),
    .i_t    (r_pat[0]),
    .i_mode (r_mode),
    .o_j    (w_j_exc),
    .o_k    (w_k_exc)
  );

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_state <= IDLE;
      r_pat   <= '0;
      r_mode  <= 1'b0;
      r_prev  <= 1'b0;
      r_idx   <= '0;
      r_drain <= 1'b0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
      r_v     <= '0;
      r_e     <= '0;
      r_i0    <= '0;
      r_i1    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_mode  <= w_mode_nxt;
      r_prev  <= w_prev_nxt;
      r_idx   <= w_idx_nxt;
      r_drain <= w_drain_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_err   <= w_err_nxt;
      r_first <= w_first_nxt;
      r_v     <= w_v_nxt;
      r_e     <= w_e_nxt;
      r_i0    <= w_i0_nxt;
      r_i1    <= w_i1_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_mode_nxt  = r_mode;
    w_prev_nxt  = r_prev;
    w_idx_nxt   = r_idx;
    w_drain_nxt = r_drain;
    w_j_nxt     = 1'b0;
    w_k_nxt     = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_push      = 1'b0;
    w_push_exp  = 1'b0;
    w_push_idx  = '0;

    w_mis       = r_v[1] && (bus.q_in != r_e[1]);
    w_err_nxt   = r_err;
    w_first_nxt = r_first;
    if (w_mis) begin
      if (r_err != '1) w_err_nxt = r_err + IDX_W'(1);
      if (r_err == '0) w_first_nxt = r_i1;
    end

    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_pat_nxt   = bus.pattern;
          w_mode_nxt  = bus.mode;
          w_prev_nxt  = 1'b0;
          w_idx_nxt   = '0;
          w_err_nxt   = '0;
          w_first_nxt = '0;
          w_pass_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_k_nxt     = 1'b1;
          // Forcing Q=0 is itself checked, tagged with the LEN sentinel.
          w_push      = 1'b1;
          w_push_exp  = 1'b0;
          w_push_idx  = IDX_W'(LEN);
          w_state_nxt = INIT;
        end
      end
      INIT, RUN: begin
        w_j_nxt     = w_j_exc;
        w_k_nxt     = w_k_exc;
        w_push      = 1'b1;
        w_push_exp  = r_pat[0];
        w_push_idx  = r_idx;
        w_prev_nxt  = r_pat[0];
        w_pat_nxt   = r_pat >> 1;
        w_idx_nxt   = r_idx + IDX_W'(1);
        if (r_idx == IDX_W'(LEN - 1)) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = 1'b0;
        end else begin
          w_state_nxt = RUN;
        end
      end
      DRAIN: begin
        if (r_drain) begin
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_pass_nxt  = (w_err_nxt == '0);
          w_state_nxt = IDLE;
        end else begin
          w_drain_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    w_v_nxt  = {r_v[0], w_push};
    w_e_nxt  = {r_e[0], w_push_exp};
    w_i1_nxt = r_i0;
    w_i0_nxt = w_push_idx;
  end

  assign bus.j_out         = r_j;
  assign bus.k_out         = r_k;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.pass          = r_pass;
  assign bus.err_count     = r_err;
  assign bus.first_err_idx = r_first;

endmodule

// File: tb/tb_jk_sequence_driver.sv
// Bench for jk_sequence_driver: a behavioural JK flop (or a stuck
// source) closes the loop; expected drives and results go through queues.
module tb_jk_sequence_driver;

  localparam int LEN   = 8;
  localparam int IDX_W = $clog2(LEN + 1);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] q_sel = 2'd0;   // 0 = flop, 1 = stuck low, 2 = stuck high
  logic       q_ff;

  int n_vec = 0;
  int n_err = 0;

  jk_sequence_driver_if #(.LEN(LEN)) bus ();

  jk_sequence_driver #(.LEN(LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) q_ff <= 1'b0;
    else begin
      case ({bus.j_out, bus.k_out})
        2'b10:   q_ff <= 1'b1;
        2'b01:   q_ff <= 1'b0;
        2'b11:   q_ff <= ~q_ff;
        default: q_ff <= q_ff;
      endcase
    end
  end

  assign bus.q_in = (q_sel == 2'd0) ? q_ff : (q_sel == 2'd2);

  typedef struct {
    logic           mode;
    logic [LEN-1:0] pattern;
    logic [1:0]     qsel;
    int             err;
    int             first;
    logic           pass;
  } vec_t;

  typedef struct {
    int   err;
    int   first;
    logic pass;
  } res_t;

  res_t       sb[$];
  logic [1:0] q_jk[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_jk(input logic p, input logic t, input logic m);
    if (p == t) return p ? {~m, 1'b0} : {1'b0, ~m};
    else if (m) return 2'b11;
    else return t ? 2'b10 : 2'b01;
  endfunction

  // Called just after a rising edge; the next rising edge accepts the start.
  task automatic run_vec(input vec_t v);
    logic       prev;
    int         cyc;
    res_t       r;
    logic [1:0] e;
    bus.mode    = v.mode;
    bus.pattern = v.pattern;
    q_sel       = v.qsel;
    bus.start   = 1'b1;
    prev = 1'b0;
    for (int s = 0; s < LEN; s++) begin
      q_jk.push_back(exp_jk(prev, v.pattern[s], v.mode));
      prev = v.pattern[s];
    end
    sb.push_back('{err: v.err, first: v.first, pass: v.pass});
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_on", bus.busy, 1);
    check("done_pulse_end", bus.done, 0);
    check("jk_force0", {bus.j_out, bus.k_out}, 2'b01);
    for (int s = 0; s < LEN; s++) begin
      @(posedge clk); #1;
      e = (q_jk.size() > 0) ? q_jk.pop_front() : 2'bxx;
      check($sformatf("jk_step%0d", s), {bus.j_out, bus.k_out}, e);
    end
    cyc = LEN;
    while (!bus.done && cyc < LEN + 6) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, LEN + 2);
    check("busy_off", bus.busy, 0);
    if (sb.size() > 0) begin
      r = sb.pop_front();
      check("err_count", bus.err_count, r.err);
      check("first_err_idx", bus.first_err_idx, r.first);
      check("pass", bus.pass, r.pass);
    end else begin
      check("scoreboard_empty", 0, 1);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int n_done;
    int done_at;
    int cyc;

    vecs[0] = '{mode: 1'b0, pattern: 8'hA5, qsel: 2'd0, err: 0, first: 0, pass: 1'b1};
    vecs[1] = '{mode: 1'b1, pattern: 8'hA5, qsel: 2'd0, err: 0, first: 0, pass: 1'b1};
    vecs[2] = '{mode: 1'b0, pattern: 8'hFF, qsel: 2'd1, err: 8, first: 0, pass: 1'b0};
    vecs[3] = '{mode: 1'b0, pattern: 8'h00, qsel: 2'd2, err: 9, first: 8, pass: 1'b0};
    vecs[4] = '{mode: 1'b1, pattern: 8'h3C, qsel: 2'd0, err: 0, first: 0, pass: 1'b1};
    vecs[5] = '{mode: 1'b0, pattern: 8'h5A, qsel: 2'd1, err: 4, first: 1, pass: 1'b0};
    vecs[6] = '{mode: 1'b1, pattern: 8'hFF, qsel: 2'd2, err: 1, first: 8, pass: 1'b0};

    bus.start   = 1'b0;
    bus.mode    = 1'b0;
    bus.pattern = '0;
    #12;
    check("rst_j", bus.j_out, 0);
    check("rst_k", bus.k_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_pass", bus.pass, 0);
    check("rst_err", bus.err_count, 0);
    check("rst_first", bus.first_err_idx, 0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back runs: each new start is raised while done is high.
    foreach (vecs[i]) run_vec(vecs[i]);
    repeat (3) @(posedge clk);
    #1;

    // Second start mid-run, with new pattern/mode, must be ignored.
    bus.mode = 1'b0; bus.pattern = 8'hA5; q_sel = 2'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.pattern = 8'h00; bus.mode = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 3; n_done = 0; done_at = 0;
    while (cyc < LEN + 8) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done) begin
        n_done++;
        done_at = cyc;
      end
    end
    check("busy_start_done_count", n_done, 1);
    check("busy_start_latency", done_at, LEN + 2);
    check("busy_start_err", bus.err_count, 0);
    check("busy_start_pass", bus.pass, 1);

    // Asynchronous reset during RUN at step 4.
    bus.mode = 1'b0; bus.pattern = 8'hA5; q_sel = 2'd0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("midrun_busy", bus.busy, 1);
    check("midrun_jk", {bus.j_out, bus.k_out}, 2'b01);
    #2 reset = 1'b0;
    #1;
    check("async_rst_j", bus.j_out, 0);
    check("async_rst_k", bus.k_out, 0);
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_done", bus.done, 0);
    check("async_rst_err", bus.err_count, 0);
    q_jk.delete();
    sb.delete();
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run_vec('{mode: 1'b0, pattern: 8'h3C, qsel: 2'd0, err: 0, first: 0, pass: 1'b1});
    @(posedge clk); #1;
    check("done_one_cycle", bus.done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/jk_sequence_driver.md
Name: jk_sequence_driver

Overview:
Stimulus/checking end of the JK flip-flop interface. Takes a target Q sequence, computes the J/K excitation for each step, drives a JK flop under test, reads its Q back and counts mismatches. Sits beside the JK flop modules on the board or bench, driving their J/K inputs and consuming their Q output.

Parameters:
LEN, 8, pattern length in steps (2..16); pattern[0] is applied first
IDX_W, $clog2(LEN+1), localparam; width of step index and error count

Ports:
clk  input  1  rising-edge clock, shared with the flop under test
reset  input  1  asynchronous, active-low; 0 clears all state immediately
start  input  1  begin a run; sampled only in IDLE
mode  input  1  don't-care resolution: 0 = set/reset style, 1 = toggle style
pattern  input  LEN  target Q sequence, latched on accepted start
q_in  input  1  Q returned from the flop under test
j_out  output  1  registered J drive
k_out  output  1  registered K drive
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at end of run
pass  output  1  err_count==0 for the last run; held until next start
err_count  output  IDX_W  mismatches in the last run
first_err_idx  output  IDX_W  step of first mismatch; LEN = init-step mismatch; 0 if none

Behaviour:
- Reset (reset=0): state IDLE; j_out=0, k_out=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0. Takes effect asynchronously, including mid-run. Reset release is synchronous to the next edge.
- States: IDLE -> INIT -> RUN -> DRAIN -> IDLE.
- IDLE: j=k=0 (hold). start=1 at edge e0 latches pattern and mode, clears counters, sets busy=1, and drives j=0, k=1 to force Q=0. Next state INIT.
- INIT (edge e1): drive excitation for pattern[0]. Expected Q=0. Next state RUN.
- RUN (edges e2..e(LEN)): at edge e(i+1), drive excitation for pattern[i].
- DRAIN: two edges with j=k=0. Then return to IDLE.
- Excitation, from the previous target p (initially 0) to the next target t:
  - 0->0: J=0, K=(mode ? 0 : 1)
  - 0->1: J=1, K=(mode ? 1 : 0)
  - 1->0: J=(mode ? 1 : 0), K=1
  - 1->1: J=(mode ? 0 : 1), K=0
- Checking is a two-deep expected-Q pipeline.
  - q_in sampled at edge e2 is compared against the init result (0).
  - q_in sampled at edge e(i+3) is compared against pattern[i].
  - The last compare happens at edge e(LEN+2).
- On mismatch: err_count increments. If it is the first mismatch, first_err_idx takes the step index (LEN for the init step). err_count cannot overflow (max LEN+1).
- At edge e(LEN+2): busy falls, done=1 for one cycle, pass=(final err_count==0), state IDLE. Start-to-done latency is LEN+2 cycles.
- start while busy: ignored. Pattern and mode changes during a run: ignored. start in the same cycle that done is asserted: accepted (state is already IDLE).

Decomposition:
- Package jk_pkg holds:
  - state enum (IDLE, INIT, RUN, DRAIN)
  - mode constants MODE_SR=0, MODE_TOGGLE=1
- Sub-module jk_excite: combinational (p, t, mode) -> (j, k) implementing the excitation rules above. Reused by later counter-design blocks.

Test Plan:
1. Function: LEN=8, mode=0, pattern=8'hA5, q_in from JK_Sync instance on same clk/reset. Required:
   - j/k for steps 0..7 = (1,0),(0,1),(1,0),(0,1),(0,1),(1,0),(0,1),(1,0)
   - done exactly 10 cycles after start edge
   - pass=1, err_count=0
2. Toggle mode: same setup, mode=1. Required: every change step drives j=k=1, every hold step drives j=k=0; pass=1.
3. Stuck-low flop: q_in tied 0, pattern=8'hFF. Required: err_count=8, first_err_idx=0, pass=0.
4. Stuck-high flop: q_in tied 1, pattern=8'h00. Required: err_count=9, first_err_idx=8 (init sentinel), pass=0.
5. Reset mid-run: reset=0 during RUN at step 4. Required: j_out=k_out=busy=done=0 with no clock edge. After release, start with 8'h3C completes with pass=1.
6. Start while busy: second start pulse at cycle 3 of a run. Required: ignored, exactly one done pulse, err_count unchanged.
